// File: rtl/normalizacion_ctrl.sv
// Sequencing controller for the FFT mantissa/exponent normalizer: one shift per clock until MSB set.
// Optional NORM_CTRL_SHIFTCNT_EN adds a shiftCnt output reporting left shifts of the current operation.
module normalizacion_ctrl #(
  parameter int SIZE = 10,
  parameter int EXPW = 5
) (
  input  logic            clkNorm,
  input  logic            rstNorm,
  input  logic            start,
  input  logic [SIZE-1:0] mantIn,
  input  logic            carryIn,
  input  logic [EXPW-1:0] expIn,
`ifdef NORM_CTRL_SHIFTCNT_EN
  output logic [$clog2(SIZE):0] shiftCnt,
`endif
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] mantOut,
  output logic [EXPW-1:0] expOut,
  output logic            zero,
  output logic            underflow,
  output logic            overflow
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EVAL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [EXPW-1:0] EXP_MAX = {EXPW{1'b1}};

  logic [1:0]      state;
  logic [SIZE-1:0] mant;
  logic [EXPW-1:0] exp_r;
  logic            carry;
`ifdef NORM_CTRL_SHIFTCNT_EN
  logic [$clog2(SIZE):0] cnt;
  assign shiftCnt = cnt;
`endif

  // NOTE: every register here, working copies included, is cleared by reset so an
  // aborted operation leaves no stale mantissa or exponent behind.
  // NOTE: sequential state uses non-blocking assignments only, so each EVAL decision
  // reads the values from before this edge.
  always_ff @(posedge clkNorm or posedge rstNorm) begin
    if (rstNorm) begin
      state     <= IDLE;
      mant      <= '0;
      exp_r     <= '0;
      carry     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mantOut   <= '0;
      expOut    <= '0;
      zero      <= 1'b0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
`ifdef NORM_CTRL_SHIFTCNT_EN
      cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // The done cycle still counts as busy, so a start seen there is dropped.
          if (done) begin
            done <= 1'b0;
            busy <= 1'b0;
          end else if (start) begin
            mant      <= mantIn;
            carry     <= carryIn;
            exp_r     <= expIn;
            zero      <= 1'b0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b1;
`ifdef NORM_CTRL_SHIFTCNT_EN
            cnt       <= '0;
`endif
            state     <= EVAL;
          end
        end

        EVAL: begin
          if (carry) begin
            mant <= {1'b1, mant[SIZE-1:1]};
            if (exp_r == EXP_MAX) overflow <= 1'b1;
            else                  exp_r    <= exp_r + 1'b1;
            state <= DONE;
          end else if (mant == '0) begin
            exp_r <= '0;
            zero  <= 1'b1;
            state <= DONE;
          end else if (mant[SIZE-1]) begin
            state <= DONE;
          end else if (exp_r == '0) begin
            underflow <= 1'b1;
            state     <= DONE;
          end else begin
            mant  <= {mant[SIZE-2:0], 1'b0};
            exp_r <= exp_r - 1'b1;
`ifdef NORM_CTRL_SHIFTCNT_EN
            cnt   <= cnt + 1'b1;
`endif
          end
        end

        DONE: begin
          mantOut <= mant;
          expOut  <= exp_r;
          done    <= 1'b1;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_normalizacion_ctrl.sv
// Self-checking bench for normalizacion_ctrl: leading-zero reference model, per-cycle compare, random stimulus.
// Builds with or without NORM_CTRL_SHIFTCNT_EN.
`timescale 1ns/1ps
module tb_normalizacion_ctrl;

  localparam int SIZE = 10;
  localparam int EXPW = 5;

  typedef struct {
    logic [SIZE-1:0] mant;
    logic [EXPW-1:0] exp;
    bit              zero;
    bit              uf;
    bit              of;
    int              n;
  } res_t;

  logic            clkNorm = 1'b0;
  logic            rstNorm = 1'b1;
  logic            start = 1'b0;
  logic [SIZE-1:0] mantIn = '0;
  logic            carryIn = 1'b0;
  logic [EXPW-1:0] expIn = '0;
  logic            busy, done, zero, underflow, overflow;
  logic [SIZE-1:0] mantOut;
  logic [EXPW-1:0] expOut;
`ifdef NORM_CTRL_SHIFTCNT_EN
  logic [$clog2(SIZE):0] shift_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int edge_cnt = 0;

  // Model state: the op in flight and the values the outputs must hold.
  bit   m_active = 0;
  int   m_k0 = 0;
  res_t m_res;
  res_t h_res = '{mant: '0, exp: '0, zero: 0, uf: 0, of: 0, n: 0};

  normalizacion_ctrl #(.SIZE(SIZE), .EXPW(EXPW)) dut (
    .clkNorm(clkNorm),
    .rstNorm(rstNorm),
    .start(start),
    .mantIn(mantIn),
    .carryIn(carryIn),
    .expIn(expIn),
`ifdef NORM_CTRL_SHIFTCNT_EN
    .shiftCnt(shift_cnt),
`endif
    .busy(busy),
    .done(done),
    .mantOut(mantOut),
    .expOut(expOut),
    .zero(zero),
    .underflow(underflow),
    .overflow(overflow)
  );

  always #5 clkNorm = ~clkNorm;
  always @(posedge clkNorm) edge_cnt = edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp = n_cmp + 1;
    if (act !== req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s @edge %0d: got %0h, required %0h", name, edge_cnt, act, req);
    end
  endtask

  // Reference: normalizing shifts = leading zeros, capped by the exponent.
  function automatic res_t model(input logic [SIZE-1:0] m, input bit c, input logic [EXPW-1:0] e);
    res_t r;
    int   lz;
    r = '{mant: m, exp: e, zero: 0, uf: 0, of: 0, n: 0};
    if (c) begin
      r.mant = (m >> 1) | (1 << (SIZE - 1));
      r.of   = (int'(e) == (1 << EXPW) - 1);
      r.exp  = r.of ? e : e + 1;
    end else if (m == 0) begin
      r.exp  = 0;
      r.zero = 1;
    end else begin
      lz = 0;
      while (((int'(m) << lz) & (1 << (SIZE - 1))) == 0) lz++;
      r.n    = (lz <= int'(e)) ? lz : int'(e);
      r.uf   = (lz > int'(e));
      r.mant = m << r.n;
      r.exp  = e - r.n;
    end
    return r;
  endfunction

  always @(negedge clkNorm) begin
    bit eb, ed;
    if (!rstNorm) begin
      ed = m_active && (edge_cnt == m_k0 + m_res.n + 2);
      eb = m_active && (edge_cnt >= m_k0) && (edge_cnt <= m_k0 + m_res.n + 2);
      if (ed) h_res = m_res;
      check("busy", busy, eb);
      check("done", done, ed);
      check("mantOut", mantOut, h_res.mant);
      check("expOut", expOut, h_res.exp);
      if (!eb || ed) begin
        check("zero", zero, h_res.zero);
        check("underflow", underflow, h_res.uf);
        check("overflow", overflow, h_res.of);
`ifdef NORM_CTRL_SHIFTCNT_EN
        check("shiftCnt", shift_cnt, h_res.n);
`endif
      end
    end
  end

  // Called just after a rising edge; presents start for the next edge.
  task automatic start_op(input logic [SIZE-1:0] m, input bit c, input logic [EXPW-1:0] e);
    int k;
    k = edge_cnt + 1;
    if (!(m_active && k <= m_k0 + m_res.n + 3)) begin
      m_res    = model(m, c, e);
      m_k0     = k;
      m_active = 1;
    end
    mantIn = m; carryIn = c; expIn = e; start = 1'b1;
    @(posedge clkNorm); #1;
    start = 1'b0;
    mantIn = SIZE'($urandom); carryIn = 1'($urandom); expIn = EXPW'($urandom);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (m_active && edge_cnt <= m_k0 + m_res.n + 3 && guard < 40) begin
      @(posedge clkNorm); #1;
      guard++;
    end
    if (guard >= 40) begin
      n_cmp = n_cmp + 1; n_fail = n_fail + 1;
      $display("FAIL wait_idle: operation still busy after 40 cycles, required completion");
    end
  endtask

  task automatic do_reset();
    rstNorm = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mantOut", mantOut, 0);
    check("rst_expOut", expOut, 0);
    check("rst_flags", {zero, underflow, overflow}, 0);
    m_active = 0;
    h_res = '{mant: '0, exp: '0, zero: 0, uf: 0, of: 0, n: 0};
    @(posedge clkNorm); #1;
    rstNorm = 1'b0;
  endtask

  initial begin
    res_t r;
    logic [SIZE-1:0] m;

    // Pin the model on hand-computed cases.
    r = model(10'b0000010110, 0, 20);
    check("model_shift_mant", r.mant, 10'b1011000000);
    check("model_shift_exp", r.exp, 15);
    check("model_shift_n", r.n, 5);
    r = model(10'b0110000001, 1, 31);
    check("model_carry_sat", {r.mant, r.exp, r.of}, {10'b1011000000, 5'd31, 1'b1});
    r = model(10'b0000000100, 0, 2);
    check("model_underflow", {r.mant, r.exp, r.uf, 8'(r.n)}, {10'b0000010000, 5'd0, 1'b1, 8'd2});

    #12;
    @(posedge clkNorm); #1;
    do_reset();

    start_op(10'b1000000000, 0, 16); wait_idle();
    check("lit_norm", {mantOut, expOut, zero, underflow, overflow}, {10'b1000000000, 5'd16, 3'b000});
    start_op(10'b0000010110, 0, 20); wait_idle();
    check("lit_shift5", {mantOut, expOut}, {10'b1011000000, 5'd15});
    start_op(10'b0110000001, 1, 31); wait_idle();
    check("lit_carry_of", {mantOut, expOut, overflow}, {10'b1011000000, 5'd31, 1'b1});
    start_op(10'b0110000001, 1, 9); wait_idle();
    check("lit_carry", {mantOut, expOut, overflow}, {10'b1011000000, 5'd10, 1'b0});
    start_op(10'b0000000000, 0, 7); wait_idle();
    check("lit_zero", {mantOut, expOut, zero}, {10'b0, 5'd0, 1'b1});
    start_op(10'b0000000100, 0, 2); wait_idle();
    check("lit_uf", {mantOut, expOut, underflow}, {10'b0000010000, 5'd0, 1'b1});

    // Start pulsed two cycles into a 5-shift op must be ignored.
    start_op(10'b0000010110, 0, 20);
    @(posedge clkNorm); #1;
    start_op(10'b0000000001, 0, 30);
    wait_idle();
    check("lit_ignore", {mantOut, expOut}, {10'b1011000000, 5'd15});

    // Reset after the third shift aborts with no done pulse.
    start_op(10'b0000011111, 0, 25);
    repeat (3) @(posedge clkNorm);
    #1;
    do_reset();
    repeat (10) @(posedge clkNorm);
    #1;
    start_op(10'b0001000000, 0, 12); wait_idle();
    check("lit_after_rst", {mantOut, expOut}, {10'b1000000000, 5'd9});

    for (int i = 0; i < 300; i++) begin
      m = SIZE'($urandom) >> $urandom_range(0, SIZE);
      start_op(m, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0) ? EXPW'($urandom_range(0, 3))
                                                                        : EXPW'($urandom));
      repeat ($urandom_range(0, 12)) @(posedge clkNorm);
      #1;
    end
    wait_idle();
    repeat (3) @(posedge clkNorm);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
